// File: rtl/dtu_seq.sv
// Sequencer that configures one dtu, then runs NUM_FRAMES loop-back frames with retry on error/timeout.
// All outputs registered (Moore); dtu handshakes are level-held until the dtu answers or the timer expires.
module dtu_seq #(
    parameter int NUM_FRAMES = 4,
    parameter int MAX_RETRY  = 2,
    parameter int TIMEOUT    = 1023
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] div_sel,
    output logic       dtu_en,
    output logic [1:0] dtu_clk_div_sel,
    output logic       dtu_clk_div_ld,
    output logic       dtu_tx_start,
    output logic [1:0] dtu_tx_character_sel,
    output logic       dtu_rx_ack,
    input  logic       dtu_tx_busy,
    input  logic       dtu_rx_busy,
    input  logic       dtu_rx_ready,
    input  logic       dtu_rx_error,
    input  logic [6:0] dtu_rx_character1,
    input  logic [6:0] dtu_rx_character2,
    output logic       busy,
    output logic       done,
    output logic       fail,
    output logic [3:0] frame_cnt,
    output logic [7:0] err_cnt,
    output logic [6:0] last_char1,
    output logic [6:0] last_char2
);
    typedef enum logic [3:0] {
        S_IDLE, S_CFG, S_LOAD, S_ENABLE, S_TX_REQ, S_TX_WAIT,
        S_RX_WAIT, S_ACK, S_NEXT, S_DONE, S_FAIL
    } state_t;

    localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT - 1);
    localparam logic [3:0]  FRAMES_END = 4'(NUM_FRAMES);
    localparam logic [2:0]  RETRY_MAX  = 3'(MAX_RETRY);

    state_t      state_q, state_d;
    logic [1:0]  div_q, div_d;
    logic [3:0]  frame_q, frame_d;
    logic [7:0]  err_q, err_d;
    logic [2:0]  retry_q, retry_d;
    logic [15:0] timer_q, timer_d;
    logic        rx_err_q, rx_err_d;
    logic [6:0]  char1_q, char1_d, char2_q, char2_d;
    logic        en_q, en_d, ld_q, ld_d, tx_start_q, tx_start_d, rx_ack_q, rx_ack_d;
    logic [1:0]  char_sel_q, char_sel_d;
    logic        busy_q, busy_d, done_q, done_d, fail_q, fail_d;
    logic        tmo, attempt_fail, err_inc, timer_restart, in_wait, rx_busy_unused;

    assign rx_busy_unused = dtu_rx_busy;

    always_comb begin
        state_d       = state_q;
        div_d         = div_q;
        frame_d       = frame_q;
        err_d         = err_q;
        retry_d       = retry_q;
        rx_err_d      = rx_err_q;
        char1_d       = char1_q;
        char2_d       = char2_q;
        attempt_fail  = 1'b0;
        err_inc       = 1'b0;
        timer_restart = 1'b0;
        tmo           = (timer_q == TMO_LAST);

        case (state_q)
            S_IDLE, S_DONE, S_FAIL: begin
                if (start) begin
                    div_d    = div_sel;
                    frame_d  = '0;
                    err_d    = '0;
                    retry_d  = '0;
                    rx_err_d = 1'b0;
                    state_d  = S_CFG;
                end
            end
            S_CFG:    state_d = S_LOAD;
            S_LOAD:   state_d = S_ENABLE;
            S_ENABLE: state_d = S_TX_REQ;
            S_TX_REQ: begin
                // The timer only runs while the strobe is actually driven (skips the retry gap cycle)
                if (dtu_tx_busy)             state_d = S_TX_WAIT;
                else if (tmo && tx_start_q)  attempt_fail = 1'b1;
            end
            S_TX_WAIT: begin
                if (!dtu_tx_busy) state_d = S_RX_WAIT;
                else if (tmo)     attempt_fail = 1'b1;
            end
            S_RX_WAIT: begin
                if (dtu_rx_ready) begin
                    rx_err_d = dtu_rx_error;
                    if (!dtu_rx_error) begin
                        char1_d = dtu_rx_character1;
                        char2_d = dtu_rx_character2;
                    end
                    state_d = S_ACK;
                end else if (tmo) begin
                    attempt_fail = 1'b1;
                end
            end
            S_ACK: begin
                if (!dtu_rx_ready) begin
                    if (rx_err_q) attempt_fail = 1'b1;
                    else          state_d = S_NEXT;
                end else if (tmo) begin
                    err_inc = 1'b1;
                    state_d = S_FAIL;
                end
            end
            S_NEXT: begin
                frame_d = frame_q + 4'd1;
                retry_d = '0;
                state_d = (frame_q + 4'd1 == FRAMES_END) ? S_DONE : S_TX_REQ;
            end
            default: state_d = S_IDLE;
        endcase

        if (attempt_fail) begin
            err_inc = 1'b1;
            if (retry_q < RETRY_MAX) begin
                retry_d       = retry_q + 3'd1;
                state_d       = S_TX_REQ;
                timer_restart = 1'b1;
            end else begin
                state_d = S_FAIL;
            end
        end
        if (err_inc && err_q != 8'hFF) err_d = err_q + 8'd1;

        in_wait = (state_q inside {S_TX_REQ, S_TX_WAIT, S_RX_WAIT, S_ACK});
        if (state_d != state_q || timer_restart || (state_q == S_TX_REQ && !tx_start_q) || !in_wait)
            timer_d = '0;
        else
            timer_d = timer_q + 16'd1;

        en_d       = (state_d inside {S_ENABLE, S_TX_REQ, S_TX_WAIT, S_RX_WAIT, S_ACK, S_NEXT});
        ld_d       = (state_d == S_LOAD);
        // A timed-out request drops the strobe for one cycle so the retry is a fresh pulse
        tx_start_d = (state_d == S_TX_REQ) && !(state_q == S_TX_REQ && timer_restart);
        char_sel_d = (state_d inside {S_TX_REQ, S_TX_WAIT, S_RX_WAIT, S_ACK}) ? frame_d[1:0] : 2'd0;
        rx_ack_d   = (state_d == S_ACK);
        busy_d     = !(state_d inside {S_IDLE, S_DONE, S_FAIL});
        done_d     = (state_d == S_DONE);
        fail_d     = (state_d == S_FAIL);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            frame_q    <= '0;
            err_q      <= '0;
            retry_q    <= '0;
            timer_q    <= '0;
            rx_err_q   <= 1'b0;
            char1_q    <= '0;
            char2_q    <= '0;
            en_q       <= 1'b0;
            ld_q       <= 1'b0;
            tx_start_q <= 1'b0;
            char_sel_q <= '0;
            rx_ack_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            frame_q    <= frame_d;
            err_q      <= err_d;
            retry_q    <= retry_d;
            timer_q    <= timer_d;
            rx_err_q   <= rx_err_d;
            char1_q    <= char1_d;
            char2_q    <= char2_d;
            en_q       <= en_d;
            ld_q       <= ld_d;
            tx_start_q <= tx_start_d;
            char_sel_q <= char_sel_d;
            rx_ack_q   <= rx_ack_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            fail_q     <= fail_d;
        end
    end

    assign dtu_en               = en_q;
    assign dtu_clk_div_sel      = div_q;
    assign dtu_clk_div_ld       = ld_q;
    assign dtu_tx_start         = tx_start_q;
    assign dtu_tx_character_sel = char_sel_q;
    assign dtu_rx_ack           = rx_ack_q;
    assign busy                 = busy_q;
    assign done                 = done_q;
    assign fail                 = fail_q;
    assign frame_cnt            = frame_q;
    assign err_cnt              = err_q;
    assign last_char1           = char1_q;
    assign last_char2           = char2_q;
endmodule

// File: tb/tb_dtu_seq.sv
// Directed bench for dtu_seq with a reactive dtu model and a tx_start scoreboard.
module tb_dtu_seq;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] div_sel = 2'd0;
    logic       dtu_en, dtu_clk_div_ld, dtu_tx_start, dtu_rx_ack;
    logic [1:0] dtu_clk_div_sel, dtu_tx_character_sel;
    logic       dtu_tx_busy = 1'b0, dtu_rx_busy = 1'b0, dtu_rx_ready = 1'b0, dtu_rx_error = 1'b0;
    logic [6:0] dtu_rx_character1 = 7'd0, dtu_rx_character2 = 7'd0;
    logic       busy, done, fail;
    logic [3:0] frame_cnt;
    logic [7:0] err_cnt;
    logic [6:0] last_char1, last_char2;

    always #5 clk = ~clk;

    dtu_seq #(.NUM_FRAMES(4), .MAX_RETRY(2), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .div_sel(div_sel),
        .dtu_en(dtu_en), .dtu_clk_div_sel(dtu_clk_div_sel), .dtu_clk_div_ld(dtu_clk_div_ld),
        .dtu_tx_start(dtu_tx_start), .dtu_tx_character_sel(dtu_tx_character_sel),
        .dtu_rx_ack(dtu_rx_ack), .dtu_tx_busy(dtu_tx_busy), .dtu_rx_busy(dtu_rx_busy),
        .dtu_rx_ready(dtu_rx_ready), .dtu_rx_error(dtu_rx_error),
        .dtu_rx_character1(dtu_rx_character1), .dtu_rx_character2(dtu_rx_character2),
        .busy(busy), .done(done), .fail(fail), .frame_cnt(frame_cnt), .err_cnt(err_cnt),
        .last_char1(last_char1), .last_char2(last_char2)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // dtu model: busy 3 cycles after tx_start, rx_ready 2 cycles later, held until rx_ack
    int         m_phase = 0, m_cnt = 0, m_err_frame = 0, m_err_left = 0;
    logic       m_nobusy = 1'b0, m_err = 1'b0;
    logic [1:0] m_sel = 2'd0;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_phase = 0; dtu_tx_busy = 0; dtu_rx_ready = 0; dtu_rx_error = 0;
        end else begin
            case (m_phase)
                0: if (dtu_tx_start && !m_nobusy) begin
                    m_sel = dtu_tx_character_sel;
                    m_err = (int'(m_sel) == m_err_frame) && (m_err_left > 0);
                    if (m_err) m_err_left--;
                    dtu_tx_busy = 1; m_cnt = 3; m_phase = 1;
                end
                1: begin
                    m_cnt--;
                    if (m_cnt == 0) begin dtu_tx_busy = 0; m_cnt = 2; m_phase = 2; end
                end
                2: begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        dtu_rx_ready = 1; dtu_rx_error = m_err;
                        dtu_rx_character1 = 7'h40 + 7'(m_sel);
                        dtu_rx_character2 = 7'h60 + 7'(m_sel);
                        m_phase = 3;
                    end
                end
                default: if (dtu_rx_ack) begin
                    dtu_rx_ready = 0; dtu_rx_error = 0; m_phase = 0;
                end
            endcase
        end
    end

    // Scoreboard: expected tx_start pulses (character select, width in cycles)
    typedef struct { int sel; int len; } exp_t;
    exp_t sb[$];
    int   ld_cycles = 0, tx_len = 0;
    logic tx_prev = 1'b0;
    int   tx_sel = 0;

    always @(negedge clk) begin
        if (dtu_clk_div_ld) ld_cycles++;
        if (dtu_tx_start) begin
            if (!tx_prev) begin tx_len = 0; tx_sel = int'(dtu_tx_character_sel); end
            tx_len++;
        end else if (tx_prev) begin
            chk("sb_pulse_expected", (sb.size() > 0) ? 1 : 0, 1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_char_sel", tx_sel, e.sel);
                chk("sb_pulse_len", tx_len, e.len);
            end
        end
        tx_prev = dtu_tx_start;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int sel, input int len);
        exp_t e;
        e.sel = sel; e.len = len;
        sb.push_back(e);
    endtask

    task automatic kick(input logic [1:0] ds);
        start = 1; div_sel = ds; ld_cycles = 0;
        step(1);
        start = 0;
    endtask

    task automatic wait_end(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done || fail) break;
            step(1);
        end
        chk("run_finished", int'(done | fail), 1);
        step(2);
    endtask

    initial begin
        step(2);
        chk("rst_busy", busy, 0);      chk("rst_done", done, 0);
        chk("rst_fail", fail, 0);      chk("rst_en", dtu_en, 0);
        chk("rst_div_sel", dtu_clk_div_sel, 0);
        chk("rst_ld", dtu_clk_div_ld, 0);
        chk("rst_tx_start", dtu_tx_start, 0);
        chk("rst_rx_ack", dtu_rx_ack, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_last_char1", last_char1, 0);
        rst_n = 1;
        step(1);

        // Clean run with start-sequence timing
        for (int k = 0; k < 4; k++) push(k, 1);
        kick(2'b01);
        chk("cfg_busy", busy, 1);  chk("cfg_en", dtu_en, 0);  chk("cfg_ld", dtu_clk_div_ld, 0);
        step(1);
        chk("load_ld", dtu_clk_div_ld, 1); chk("load_sel", dtu_clk_div_sel, 1); chk("load_en", dtu_en, 0);
        step(1);
        chk("enable_en", dtu_en, 1); chk("enable_ld", dtu_clk_div_ld, 0); chk("enable_tx", dtu_tx_start, 0);
        step(1);
        chk("first_tx_start", dtu_tx_start, 1);
        wait_end(400);
        chk("clean_done", done, 1);           chk("clean_frames", frame_cnt, 4);
        chk("clean_err", err_cnt, 0);         chk("clean_en_off", dtu_en, 0);
        chk("clean_char1", last_char1, 'h43); chk("clean_char2", last_char2, 'h63);
        chk("clean_ld_cycles", ld_cycles, 1); chk("clean_sb_empty", sb.size(), 0);

        // One rx_error on frame 1
        m_err_frame = 1; m_err_left = 1;
        push(0, 1); push(1, 1); push(1, 1); push(2, 1); push(3, 1);
        kick(2'b01);
        chk("done_clears", done, 0);
        wait_end(400);
        chk("err1_done", done, 1);  chk("err1_frames", frame_cnt, 4);
        chk("err1_err", err_cnt, 1); chk("err1_sb_empty", sb.size(), 0);

        // Frame 0 fails three times -> FAIL
        m_err_frame = 0; m_err_left = 3;
        push(0, 1); push(0, 1); push(0, 1);
        kick(2'b00);
        wait_end(400);
        chk("err3_fail", fail, 1);  chk("err3_done", done, 0);
        chk("err3_err", err_cnt, 3); chk("err3_frames", frame_cnt, 0);
        chk("err3_en", dtu_en, 0);   chk("err3_sb_empty", sb.size(), 0);
        m_err_left = 0;

        // tx_busy never rises -> three 15-cycle attempts then FAIL
        m_nobusy = 1;
        push(0, 15); push(0, 15); push(0, 15);
        kick(2'b00);
        chk("fail_clears", fail, 0);
        wait_end(400);
        chk("tmo_fail", fail, 1); chk("tmo_err", err_cnt, 3);
        chk("tmo_sb_empty", sb.size(), 0);
        m_nobusy = 0;

        // Reset during RX_WAIT of frame 2, then a clean run
        push(0, 1); push(1, 1); push(2, 1);
        kick(2'b01);
        begin
            int i;
            for (i = 0; i < 400; i++) begin
                if (dtu_tx_character_sel == 2'd2 && m_phase == 2) break;
                step(1);
            end
            chk("reach_rx_wait_f2", (i < 400) ? 1 : 0, 1);
        end
        rst_n = 0;
        step(1);
        chk("mrst_en", dtu_en, 0);        chk("mrst_busy", busy, 0);
        chk("mrst_frames", frame_cnt, 0); chk("mrst_char_sel", dtu_tx_character_sel, 0);
        chk("mrst_rx_ack", dtu_rx_ack, 0); chk("mrst_div_sel", dtu_clk_div_sel, 0);
        chk("mrst_sb_empty", sb.size(), 0);
        rst_n = 1;
        step(1);
        for (int k = 0; k < 4; k++) push(k, 1);
        kick(2'b01);
        wait_end(400);
        chk("post_rst_done", done, 1); chk("post_rst_frames", frame_cnt, 4);
        chk("post_rst_err", err_cnt, 0);

        // start during TX_WAIT is ignored
        for (int k = 0; k < 4; k++) push(k, 1);
        kick(2'b10);
        begin
            int i;
            for (i = 0; i < 100; i++) begin
                if (dtu_tx_busy && !dtu_tx_start && busy) break;
                step(1);
            end
            chk("reach_tx_wait", (i < 100) ? 1 : 0, 1);
        end
        start = 1; div_sel = 2'b11;
        step(1);
        start = 0;
        chk("ign_frames", frame_cnt, 0); chk("ign_div_sel", dtu_clk_div_sel, 2);
        chk("ign_busy", busy, 1);
        wait_end(400);
        chk("ign_done", done, 1);        chk("ign_final_frames", frame_cnt, 4);
        chk("ign_final_div", dtu_clk_div_sel, 2);
        chk("ign_ld_cycles", ld_cycles, 1);
        chk("ign_sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
